// File: rtl/mem_stage_requester.sv
// MEM-stage load/store initiator for a negedge-sampled data memory; define MEM_REQ_ALIGN_CHECK_EN to reject misaligned addresses.
// Latency to resp_valid: store 2, load LATENCY+2, reject 1 cycle; req_ready only in IDLE, freeze stalls the pipeline while busy.
module mem_stage_requester #(
  parameter logic [31:0] BASE_ADDR = 32'd1024,
  parameter int unsigned MEM_BYTES = 32,
  parameter int unsigned LATENCY   = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [31:0] req_adr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic        freeze,
  output logic [31:0] mem_adr,
  output logic [31:0] mem_data_in,
  output logic        MEM_R_EN,
  output logic        MEM_W_EN,
  input  logic [31:0] mem_rdata
);

  typedef enum logic [1:0] {IDLE, REQ, WAIT, RESP} state_t;

  typedef struct packed {
    logic        we;
    logic [29:0] word;
    logic [31:0] wdata;
  } req_t;

  localparam logic [31:0] LAST_OFF = 32'(MEM_BYTES - 4);
  localparam logic [3:0]  LAT      = 4'(LATENCY);

  state_t      state;
  req_t        rq;
  logic [3:0]  cnt;
  logic [31:0] off;
  logic        reject;

  // Addresses below the window wrap to a huge offset and fail the same compare.
  assign off = req_adr - BASE_ADDR;
`ifdef MEM_REQ_ALIGN_CHECK_EN
  assign reject = (off > LAST_OFF) || (req_adr[1:0] != 2'b00);
`else
  assign reject = (off > LAST_OFF);
`endif

  assign req_ready   = (state == IDLE);
  assign freeze      = (state == REQ) || (state == WAIT) || ((state == IDLE) && req_valid);
  assign mem_adr     = {rq.word, 2'b00};
  assign mem_data_in = rq.wdata;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      rq         <= '0;
      cnt        <= '0;
      resp_valid <= 1'b0;
      resp_err   <= 1'b0;
      resp_rdata <= '0;
      MEM_R_EN   <= 1'b0;
      MEM_W_EN   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            rq         <= '{we: req_we, word: req_adr[31:2], wdata: req_wdata};
            resp_rdata <= '0;
            if (reject) begin
              state      <= RESP;
              resp_valid <= 1'b1;
              resp_err   <= 1'b1;
            end else begin
              state    <= REQ;
              resp_err <= 1'b0;
              MEM_W_EN <= req_we;
              MEM_R_EN <= !req_we;
            end
          end
        end
        REQ: begin
          MEM_W_EN <= 1'b0;
          if (rq.we) begin
            state      <= RESP;
            resp_valid <= 1'b1;
          end else begin
            state <= WAIT;
            cnt   <= LAT;
          end
        end
        WAIT: begin
          cnt <= cnt - 4'd1;
          if (cnt == 4'd1) begin
            resp_rdata <= mem_rdata;
            MEM_R_EN   <= 1'b0;
            resp_valid <= 1'b1;
            state      <= RESP;
          end
        end
        RESP: begin
          resp_valid <= 1'b0;
          resp_err   <= 1'b0;
          state      <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_stage_requester.sv
// Two requesters (LATENCY 1 and 3) on negedge memories, checked every cycle against a transaction-timeline model.
module tb_mem_stage_requester;
  localparam logic [31:0] BASE = 32'd1024;
  localparam int MEMB = 32;
  localparam int LAT0 = 1;
  localparam int LAT1 = 3;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic        req_valid   [2];
  logic        req_we      [2];
  logic [31:0] req_adr     [2];
  logic [31:0] req_wdata   [2];
  logic        req_ready   [2];
  logic        resp_valid  [2];
  logic [31:0] resp_rdata  [2];
  logic        resp_err    [2];
  logic        freeze      [2];
  logic [31:0] mem_adr     [2];
  logic [31:0] mem_data_in [2];
  logic        mem_r_en    [2];
  logic        mem_w_en    [2];
  logic [31:0] mem_rdata   [2];

  mem_stage_requester #(.BASE_ADDR(BASE), .MEM_BYTES(MEMB), .LATENCY(LAT0)) u0 (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid[0]), .req_ready(req_ready[0]),
    .req_we(req_we[0]), .req_adr(req_adr[0]), .req_wdata(req_wdata[0]),
    .resp_valid(resp_valid[0]), .resp_rdata(resp_rdata[0]), .resp_err(resp_err[0]),
    .freeze(freeze[0]), .mem_adr(mem_adr[0]), .mem_data_in(mem_data_in[0]),
    .MEM_R_EN(mem_r_en[0]), .MEM_W_EN(mem_w_en[0]), .mem_rdata(mem_rdata[0]));

  mem_stage_requester #(.BASE_ADDR(BASE), .MEM_BYTES(MEMB), .LATENCY(LAT1)) u1 (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid[1]), .req_ready(req_ready[1]),
    .req_we(req_we[1]), .req_adr(req_adr[1]), .req_wdata(req_wdata[1]),
    .resp_valid(resp_valid[1]), .resp_rdata(resp_rdata[1]), .resp_err(resp_err[1]),
    .freeze(freeze[1]), .mem_adr(mem_adr[1]), .mem_data_in(mem_data_in[1]),
    .MEM_R_EN(mem_r_en[1]), .MEM_W_EN(mem_w_en[1]), .mem_rdata(mem_rdata[1]));

  int n_chk  = 0;
  int n_pass = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
  endtask

  // Memory devices: sample on negedge, reload a known pattern while reset is low.
  logic [31:0] dev_mem [2][8];
  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (!rst_n) begin
        for (int w = 0; w < 8; w++) dev_mem[i][w] <= {16'hC0DE, 8'(i), 8'(w)};
        mem_rdata[i] <= '0;
      end else begin
        if (mem_w_en[i]) dev_mem[i][mem_adr[i][4:2]] <= mem_data_in[i];
        if (mem_r_en[i]) mem_rdata[i] <= dev_mem[i][mem_adr[i][4:2]];
      end
    end
  end

  function automatic logic rejects(input logic [31:0] a);
    logic [31:0] off;
    logic r;
    off = a - BASE;
    r = off > 32'(MEMB - 4);
`ifdef MEM_REQ_ALIGN_CHECK_EN
    r = r | (a[1:0] != 2'b00);
`endif
    return r;
  endfunction

  // Model: each accepted request occupies cycles [acc, resp]; enables cover [acc, resp-1].
  int          cyc = 0;
  logic        t_vld   [2] = '{1'b0, 1'b0};
  int          t_acc   [2];
  int          t_resp  [2];
  logic        t_we    [2];
  logic        t_err   [2];
  logic [31:0] t_adr   [2];
  logic [31:0] t_wdata [2];
  logic [31:0] t_rdata [2];
  logic [31:0] ref_mem [2][8];
  int          lat_of  [2] = '{LAT0, LAT1};

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 2; i++) begin
        t_vld[i] <= 1'b0;
        for (int w = 0; w < 8; w++) ref_mem[i][w] <= {16'hC0DE, 8'(i), 8'(w)};
      end
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (req_valid[i] && (!t_vld[i] || cyc > t_resp[i])) begin
          logic [31:0] off;
          logic        er;
          off = req_adr[i] - BASE;
          er  = rejects(req_adr[i]);
          t_vld[i]   <= 1'b1;
          t_acc[i]   <= cyc + 1;
          t_we[i]    <= req_we[i];
          t_err[i]   <= er;
          t_adr[i]   <= {req_adr[i][31:2], 2'b00};
          t_wdata[i] <= req_wdata[i];
          t_resp[i]  <= cyc + 1 + (er ? 0 : (req_we[i] ? 1 : lat_of[i] + 1));
          t_rdata[i] <= (er || req_we[i]) ? 32'h0 : ref_mem[i][off[4:2]];
          if (!er && req_we[i]) ref_mem[i][off[4:2]] <= req_wdata[i];
        end
      end
      cyc <= cyc + 1;
    end
  end

  // Per-cycle compare plus observation logs used by the directed checks.
  int          n_acc   [2] = '{0, 0};
  int          n_resp  [2] = '{0, 0};
  int          wen_cnt [2] = '{0, 0};
  int          ren_cnt [2] = '{0, 0};
  logic [31:0] wen_adr [2];
  int          acc_log   [2][64];
  int          resp_log  [2][64];
  logic [31:0] rdata_log [2][64];
  logic        err_log   [2][64];
  logic        frz_log   [2][64];

  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      logic idle, e_resp, e_win;
      idle   = !t_vld[i] || (cyc > t_resp[i]);
      e_resp = t_vld[i] && (cyc == t_resp[i]);
      e_win  = !idle && !e_resp && !t_err[i];
      check($sformatf("u%0d.req_ready@%0d", i, cyc), 32'(req_ready[i]), 32'(idle));
      check($sformatf("u%0d.resp_valid@%0d", i, cyc), 32'(resp_valid[i]), 32'(e_resp));
      check($sformatf("u%0d.MEM_W_EN@%0d", i, cyc), 32'(mem_w_en[i]), 32'(e_win && t_we[i]));
      check($sformatf("u%0d.MEM_R_EN@%0d", i, cyc), 32'(mem_r_en[i]), 32'(e_win && !t_we[i]));
      check($sformatf("u%0d.freeze@%0d", i, cyc), 32'(freeze[i]), 32'(idle ? req_valid[i] : !e_resp));
      if (e_resp) begin
        check($sformatf("u%0d.resp_err@%0d", i, cyc), 32'(resp_err[i]), 32'(t_err[i]));
        check($sformatf("u%0d.resp_rdata@%0d", i, cyc), resp_rdata[i], t_rdata[i]);
      end
      if (e_win) check($sformatf("u%0d.mem_adr@%0d", i, cyc), mem_adr[i], t_adr[i]);
      if (e_win && t_we[i]) check($sformatf("u%0d.mem_data_in@%0d", i, cyc), mem_data_in[i], t_wdata[i]);

      if (rst_n && req_valid[i] && req_ready[i]) begin
        acc_log[i][n_acc[i] % 64] = cyc + 1;
        n_acc[i]++;
      end
      if (resp_valid[i]) begin
        resp_log[i][n_resp[i] % 64]  = cyc;
        rdata_log[i][n_resp[i] % 64] = resp_rdata[i];
        err_log[i][n_resp[i] % 64]   = resp_err[i];
        frz_log[i][n_resp[i] % 64]   = freeze[i];
        n_resp[i]++;
      end
      if (mem_w_en[i]) begin
        wen_cnt[i]++;
        wen_adr[i] = mem_adr[i];
      end
      if (mem_r_en[i]) ren_cnt[i]++;
    end
  end

  task automatic wait_acc(input int i, input int target);
    logic ok;
    ok = 1'b0;
    for (int k = 0; k < 40 && !ok; k++) begin
      @(posedge clk); #2;
      ok = (n_acc[i] >= target);
    end
    check($sformatf("u%0d.accept_within_budget", i), 32'(ok), 32'd1);
  endtask

  task automatic wait_resp(input int i, input int target);
    logic ok;
    ok = 1'b0;
    for (int k = 0; k < 40 && !ok; k++) begin
      @(posedge clk); #2;
      ok = (n_resp[i] >= target);
    end
    check($sformatf("u%0d.resp_within_budget", i), 32'(ok), 32'd1);
  endtask

  int          o_lat, o_dwen, o_dren;
  logic [31:0] o_rdata, o_wadr;
  logic        o_err, o_frz;

  task automatic txn(input int i, input logic we, input logic [31:0] adr, input logic [31:0] wd);
    int na, nr, w0, r0;
    na = n_acc[i]; nr = n_resp[i]; w0 = wen_cnt[i]; r0 = ren_cnt[i];
    req_valid[i] = 1'b1; req_we[i] = we; req_adr[i] = adr; req_wdata[i] = wd;
    wait_acc(i, na + 1);
    req_valid[i] = 1'b0;
    wait_resp(i, nr + 1);
    o_lat   = resp_log[i][nr % 64] - acc_log[i][na % 64];
    o_rdata = rdata_log[i][nr % 64];
    o_err   = err_log[i][nr % 64];
    o_frz   = frz_log[i][nr % 64];
    o_dwen  = wen_cnt[i] - w0;
    o_dren  = ren_cnt[i] - r0;
    o_wadr  = wen_adr[i];
  endtask

  initial begin
    int na, nr;
    rst_n = 1'b0;
    for (int i = 0; i < 2; i++) begin
      req_valid[i] = 1'b0; req_we[i] = 1'b0; req_adr[i] = '0; req_wdata[i] = '0;
    end
    repeat (3) @(posedge clk);
    #1;
    check("reset_req_ready", 32'(req_ready[0]), 32'd1);
    check("reset_resp_valid", 32'(resp_valid[0]), 32'd0);
    check("reset_enables", {30'd0, mem_r_en[0], mem_w_en[0]}, 32'd0);
    check("reset_mem_adr", mem_adr[0], 32'd0);
    #1 rst_n = 1'b1;

    // Store then load back through the LATENCY=1 instance.
    txn(0, 1'b1, 32'd1028, 32'hDEADBEEF);
    check("t1_wen_cycles", 32'(o_dwen), 32'd1);
    check("t1_wen_adr", o_wadr, 32'd1028);
    check("t1_ren_cycles", 32'(o_dren), 32'd0);
    check("t1_err", 32'(o_err), 32'd0);
    check("t1_rdata", o_rdata, 32'd0);
    check("t1_resp_offset", 32'(o_lat), 32'd1);

    txn(0, 1'b0, 32'd1028, 32'h0);
    check("t2_ren_cycles", 32'(o_dren), 32'd2);
    check("t2_rdata", o_rdata, 32'hDEADBEEF);
    check("t2_resp_offset", 32'(o_lat), 32'd2);
    check("t2_freeze_in_resp", 32'(o_frz), 32'd0);

    // Window edges: below base, one past the end, and the last valid word.
    txn(0, 1'b0, 32'd1020, 32'h0);
    check("t3a_err", 32'(o_err), 32'd1);
    check("t3a_rdata", o_rdata, 32'd0);
    check("t3a_enables", 32'(o_dren + o_dwen), 32'd0);
    check("t3a_resp_offset", 32'(o_lat), 32'd0);
    txn(0, 1'b0, 32'd1056, 32'h0);
    check("t3b_err", 32'(o_err), 32'd1);
    check("t3b_rdata", o_rdata, 32'd0);
    check("t3b_enables", 32'(o_dren + o_dwen), 32'd0);
    txn(0, 1'b0, 32'd1052, 32'h0);
    check("t3c_err", 32'(o_err), 32'd0);
    check("t3c_rdata", o_rdata, 32'hC0DE0007);

    // Misaligned store.
    txn(0, 1'b1, 32'd1030, 32'h12345678);
`ifdef MEM_REQ_ALIGN_CHECK_EN
    check("t4_err", 32'(o_err), 32'd1);
    check("t4_wen_cycles", 32'(o_dwen), 32'd0);
    txn(0, 1'b0, 32'd1028, 32'h0);
    check("t4_readback", o_rdata, 32'hDEADBEEF);
`else
    check("t4_err", 32'(o_err), 32'd0);
    check("t4_wen_cycles", 32'(o_dwen), 32'd1);
    check("t4_wen_adr", o_wadr, 32'd1028);
    txn(0, 1'b0, 32'd1028, 32'h0);
    check("t4_readback", o_rdata, 32'h12345678);
`endif

    // Reset in the middle of a load's WAIT cycle.
    na = n_acc[0];
    req_valid[0] = 1'b1; req_we[0] = 1'b0; req_adr[0] = 32'd1032;
    wait_acc(0, na + 1);
    req_valid[0] = 1'b0;
    @(posedge clk); #3;
    check("t5_ren_before_reset", 32'(mem_r_en[0]), 32'd1);
    nr = n_resp[0];
    rst_n = 1'b0;
    #1;
    check("t5_ren_async_drop", 32'(mem_r_en[0]), 32'd0);
    check("t5_resp_valid_low", 32'(resp_valid[0]), 32'd0);
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
    @(posedge clk); #2;
    check("t5_no_resp_issued", 32'(n_resp[0] - nr), 32'd0);
    check("t5_ready_after", 32'(req_ready[0]), 32'd1);
    txn(0, 1'b0, 32'd1028, 32'h0);
    check("t5_next_load_err", 32'(o_err), 32'd0);
    check("t5_next_load_rdata", o_rdata, 32'hC0DE0001);
    check("t5_next_load_offset", 32'(o_lat), 32'd2);

    // Back-to-back loads on the LATENCY=3 instance with req_valid held.
    na = n_acc[1]; nr = n_resp[1];
    req_valid[1] = 1'b1; req_we[1] = 1'b0; req_adr[1] = 32'd1024;
    wait_acc(1, na + 1);
    req_adr[1] = 32'd1052;
    wait_acc(1, na + 2);
    req_valid[1] = 1'b0;
    wait_resp(1, nr + 2);
    check("t6_first_offset", 32'(resp_log[1][nr % 64] - acc_log[1][na % 64]), 32'd4);
    check("t6_second_accept_gap", 32'(acc_log[1][(na + 1) % 64] - resp_log[1][nr % 64]), 32'd2);
    check("t6_second_offset", 32'(resp_log[1][(nr + 1) % 64] - acc_log[1][(na + 1) % 64]), 32'd4);
    check("t6_first_rdata", rdata_log[1][nr % 64], 32'hC0DE0100);
    check("t6_second_rdata", rdata_log[1][(nr + 1) % 64], 32'hC0DE0107);

    repeat (4) @(posedge clk);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
